// File: rtl/clm_pkg.sv
// Shared types and helpers for conv_latency_monitor.
//   - clm_state_e      : measurement FSM states
//   - rec_w / *_off    : result record width and field offsets
//   - argmin           : lowest index holding the minimum latency
package clm_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MEASURE = 2'd1,
    PUSH    = 2'd2
  } clm_state_e;

  localparam int ID_W      = 8;
  localparam int FAST_W    = 3;   // fastest-channel index, covers up to 8 channels
  localparam int MAX_CH    = 8;
  localparam int MAX_CNT_W = 16;  // argmin operand width; CNT_W must not exceed it

  // Record, MSB to LSB: id, fastest, faster[], timeout[], lat[N-1]..lat[0]
  function automatic int rec_w(input int n_ch, input int cnt_w);
    return ID_W + FAST_W + 2*n_ch + n_ch*cnt_w;
  endfunction

  function automatic int lat_off(input int k, input int cnt_w);
    return k*cnt_w;
  endfunction

  function automatic int tmo_off(input int n_ch, input int cnt_w);
    return n_ch*cnt_w;
  endfunction

  function automatic int fst_off(input int n_ch, input int cnt_w);
    return tmo_off(n_ch, cnt_w) + n_ch;
  endfunction

  function automatic int fidx_off(input int n_ch, input int cnt_w);
    return fst_off(n_ch, cnt_w) + n_ch;
  endfunction

  function automatic int id_off(input int n_ch, input int cnt_w);
    return fidx_off(n_ch, cnt_w) + FAST_W;
  endfunction

  // Strict '<' while scanning upward keeps the lowest index on ties.
  function automatic logic [FAST_W-1:0] argmin(
    input logic [MAX_CH-1:0][MAX_CNT_W-1:0] v,
    input int                               n_ch
  );
    logic [MAX_CNT_W-1:0] best;
    logic [FAST_W-1:0]    idx;
    best = v[0];
    idx  = '0;
    for (int i = 1; i < MAX_CH; i++) begin
      if (i < n_ch && v[i] < best) begin
        best = v[i];
        idx  = FAST_W'(i);
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/clm_result_fifo.sv
// First-word-fall-through result FIFO, DEPTH x WIDTH.
//   push/wdata : write request; accepted when not full or when popping this clk
//   pop        : read request; ignored when empty
//   rdata      : head entry, forced to zero while empty
//   count      : entries held (0..DEPTH)
//   full/empty : occupancy flags
// DEPTH must be a power of two and at least 2 so the pointers wrap naturally.
module clm_result_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);

  logic [DEPTH-1:0][WIDTH-1:0] mem;
  logic [AW-1:0]               wptr, rptr;
  logic                        rd_ok, wr_ok;

  assign empty = (count == '0);
  assign full  = (count == (AW+1)'(DEPTH));
  assign rd_ok = pop && !empty;
  // A full FIFO still takes a write when the head leaves in the same clk.
  assign wr_ok = push && (!full || rd_ok);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (wr_ok) wptr <= wptr + 1'b1;
      if (rd_ok) rptr <= rptr + 1'b1;
      case ({wr_ok, rd_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  // Storage needs no reset; rdata is gated by empty.
  always_ff @(posedge clk) begin
    if (wr_ok) mem[wptr] <= wdata;
  end

  assign rdata = empty ? '0 : mem[rptr];

endmodule

// File: rtl/conv_latency_monitor.sv
// Convergence-latency monitor. Each trans_start opens a window of up to
// MAX_CYC gamma cycles; each channel's latency is the first sampled cycle
// where its error is <= TOL. One record per window goes to a result FIFO.
//   clk, rst          : clock, async active-high reset
//   cycle_start       : gamma cycle boundary pulse (sampling strobe)
//   trans_start/id    : begin a measurement, tag latched on acceptance
//   err_in            : packed per-channel error, ch k at [k*ERR_W +: ERR_W]
//   busy              : measurement in progress (MEASURE or PUSH)
//   res_valid/ready   : FIFO head handshake; res_data is the head record
//   overflow          : sticky, a record was dropped on a full FIFO
//   collision         : sticky, trans_start arrived while busy
//   clr_flags         : clears overflow/collision; a same-clk set wins
module conv_latency_monitor
  import clm_pkg::*;
#(
  parameter int N_CH       = 2,
  parameter int ERR_W      = 8,
  parameter int CNT_W      = 8,
  parameter int TOL        = 5,
  parameter int MAX_CYC    = 10,
  parameter int REF_CH     = 0,
  parameter int EARLY_STOP = 1,
  parameter int DEPTH      = 8
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              cycle_start,
  input  logic                              trans_start,
  input  logic [7:0]                        trans_id,
  input  logic [N_CH*ERR_W-1:0]             err_in,
  output logic                              busy,
  output logic                              res_valid,
  input  logic                              res_ready,
  output logic [rec_w(N_CH, CNT_W)-1:0]     res_data,
  output logic                              overflow,
  output logic                              collision,
  input  logic                              clr_flags
);

  localparam int REC_W  = rec_w(N_CH, CNT_W);
  localparam int TMO_O  = tmo_off(N_CH, CNT_W);
  localparam int FST_O  = fst_off(N_CH, CNT_W);
  localparam int FIDX_O = fidx_off(N_CH, CNT_W);
  localparam int ID_O   = id_off(N_CH, CNT_W);
  localparam int AW     = $clog2(DEPTH);

  clm_state_e state_q, state_d;

  logic [ID_W-1:0]                   id_q;
  logic [CNT_W-1:0]                  cyc_cnt, cyc_nxt;
  logic [N_CH-1:0][CNT_W-1:0]        lat_q, lat_nxt, lat_fin;
  logic [N_CH-1:0]                   conv_mask, mask_nxt, hit;
  logic [N_CH-1:0]                   timeout, faster;
  logic [MAX_CH-1:0][MAX_CNT_W-1:0]  lat_ext;
  logic [FAST_W-1:0]                 fastest;
  logic [REC_W-1:0]                  rec;
  logic                              win_done, push_req, pop, drop, coll_evt;
  logic                              fifo_full, fifo_empty;
  logic [AW:0]                       fifo_cnt;

  // ---------------- per-channel convergence ----------------
  assign cyc_nxt = cyc_cnt + 1'b1;

  for (genvar k = 0; k < N_CH; k++) begin : g_ch
    logic [ERR_W-1:0] err;
    assign err         = err_in[k*ERR_W +: ERR_W];
    assign hit[k]      = !conv_mask[k] && (err <= ERR_W'(TOL));
    assign mask_nxt[k] = conv_mask[k] | hit[k];
    assign lat_nxt[k]  = hit[k] ? cyc_nxt : lat_q[k];
    // Unconverged channels report the full window and flag a timeout.
    assign lat_fin[k]  = conv_mask[k] ? lat_q[k] : CNT_W'(MAX_CYC);
    assign timeout[k]  = !conv_mask[k];
    // Reference channel compares against itself, so it is never faster.
    assign faster[k]   = conv_mask[k] && (lat_fin[k] < lat_fin[REF_CH]);
    assign lat_ext[k]  = MAX_CNT_W'(lat_fin[k]);
  end

  for (genvar k = N_CH; k < MAX_CH; k++) begin : g_pad
    assign lat_ext[k] = '0;
  end

  assign fastest = argmin(lat_ext, N_CH);

  assign win_done = cycle_start &&
                    ((cyc_nxt == CNT_W'(MAX_CYC)) ||
                     ((EARLY_STOP != 0) && (&mask_nxt)));

  // ---------------- FSM ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    busy     = 1'b1;
    push_req = 1'b0;
    case (state_q)
      IDLE: begin
        busy = 1'b0;
        if (trans_start) state_d = MEASURE;
      end
      MEASURE: if (win_done) state_d = PUSH;
      PUSH: begin
        push_req = 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign pop      = res_valid && res_ready;
  assign drop     = push_req && fifo_full && !pop;
  assign coll_evt = trans_start && (state_q != IDLE);

  // ---------------- datapath and sticky flags ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      id_q      <= '0;
      cyc_cnt   <= '0;
      lat_q     <= '0;
      conv_mask <= '0;
      overflow  <= 1'b0;
      collision <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (trans_start) begin
          // A cycle_start in this clk is deliberately not sampled.
          id_q      <= trans_id;
          cyc_cnt   <= '0;
          lat_q     <= '0;
          conv_mask <= '0;
        end
        MEASURE: if (cycle_start) begin
          cyc_cnt   <= cyc_nxt;
          lat_q     <= lat_nxt;
          conv_mask <= mask_nxt;
        end
        default: ;
      endcase

      if (drop)           overflow <= 1'b1;
      else if (clr_flags) overflow <= 1'b0;

      if (coll_evt)       collision <= 1'b1;
      else if (clr_flags) collision <= 1'b0;
    end
  end

  // ---------------- record assembly ----------------
  always_comb begin
    rec = '0;
    for (int k = 0; k < N_CH; k++) rec[lat_off(k, CNT_W) +: CNT_W] = lat_fin[k];
    rec[TMO_O  +: N_CH]   = timeout;
    rec[FST_O  +: N_CH]   = faster;
    rec[FIDX_O +: FAST_W] = fastest;
    rec[ID_O   +: ID_W]   = id_q;
  end

  clm_result_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (REC_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push_req),
    .wdata (rec),
    .pop   (pop),
    .rdata (res_data),
    .count (fifo_cnt),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign res_valid = !fifo_empty;

  // Occupancy and full flag must never disagree.
  a_full_cnt: assert property (@(posedge clk) disable iff (rst)
    fifo_full == (fifo_cnt == (AW+1)'(DEPTH)));

endmodule

// File: tb/tb_conv_latency_monitor.sv
module tb_conv_latency_monitor;

  logic        clk = 1'b0;
  logic        rst;
  logic        cycle_start, trans_start_a, trans_start_b, clr_flags;
  logic [7:0]  trans_id;
  logic [15:0] err_in;
  logic        res_ready_a, res_ready_b;
  logic        busy_a, busy_b, res_valid_a, res_valid_b;
  logic        overflow_a, overflow_b, collision_a, collision_b;
  logic [30:0] res_data_a, res_data_b;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  conv_latency_monitor #(
    .N_CH(2), .ERR_W(8), .CNT_W(8), .TOL(5), .MAX_CYC(10),
    .REF_CH(0), .EARLY_STOP(1), .DEPTH(8)
  ) dut_a (
    .clk(clk), .rst(rst), .cycle_start(cycle_start), .trans_start(trans_start_a),
    .trans_id(trans_id), .err_in(err_in), .busy(busy_a), .res_valid(res_valid_a),
    .res_ready(res_ready_a), .res_data(res_data_a), .overflow(overflow_a),
    .collision(collision_a), .clr_flags(clr_flags)
  );

  conv_latency_monitor #(
    .N_CH(2), .ERR_W(8), .CNT_W(8), .TOL(5), .MAX_CYC(10),
    .REF_CH(0), .EARLY_STOP(0), .DEPTH(8)
  ) dut_b (
    .clk(clk), .rst(rst), .cycle_start(cycle_start), .trans_start(trans_start_b),
    .trans_id(trans_id), .err_in(err_in), .busy(busy_b), .res_valid(res_valid_b),
    .res_ready(res_ready_b), .res_data(res_data_b), .overflow(overflow_b),
    .collision(collision_b), .clr_flags(clr_flags)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [30:0] mk_rec(input logic [7:0] id, input logic [2:0] fi,
                                         input logic [1:0] fa, input logic [1:0] to,
                                         input logic [7:0] l1, input logic [7:0] l0);
    return {id, fi, fa, to, l1, l0};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_a(input logic [7:0] id);
    trans_id = id; trans_start_a = 1'b1; tick(); trans_start_a = 1'b0;
  endtask

  // One sampled gamma cycle: errors and strobe presented for one clk.
  task automatic gamma(input logic [7:0] e0, input logic [7:0] e1);
    err_in = {e1, e0}; cycle_start = 1'b1; tick(); cycle_start = 1'b0;
  endtask

  task automatic pop_a();
    res_ready_a = 1'b1; tick(); res_ready_a = 1'b0;
  endtask

  initial begin
    rst = 1'b1; cycle_start = 0; trans_start_a = 0; trans_start_b = 0; clr_flags = 0;
    trans_id = 0; err_in = '0; res_ready_a = 0; res_ready_b = 0;
    repeat (2) tick();
    check("rst_busy", busy_a, 0);
    check("rst_valid", res_valid_a, 0);
    check("rst_data", res_data_a, 0);
    check("rst_ovf", overflow_a, 0);
    check("rst_coll", collision_a, 0);
    rst = 1'b0; tick();

    // T1: ch0 at cycle 2, ch1 at cycle 5; a coincident cycle_start at start is ignored
    trans_id = 8'd3; trans_start_a = 1; cycle_start = 1; err_in = '0; tick();
    trans_start_a = 0; cycle_start = 0;
    check("t1_busy_start", busy_a, 1);
    for (int c = 1; c <= 5; c++) begin
      gamma((c >= 2) ? 8'd4 : 8'd9, (c >= 5) ? 8'd4 : 8'd9);
      if (c < 5) tick();
    end
    check("t1_busy_push", busy_a, 1);
    tick();
    check("t1_busy_done", busy_a, 0);
    check("t1_valid", res_valid_a, 1);
    check("t1_rec", res_data_a, mk_rec(8'd3, 3'd0, 2'b00, 2'b00, 8'd5, 8'd2));
    pop_a();
    check("t1_empty", res_valid_a, 0);

    // T2: ch1 converges at exactly TOL on cycle 1, ch0 rejects 6 then takes 5 on cycle 3
    start_a(8'd4);
    gamma(8'd9, 8'd5); tick();
    gamma(8'd6, 8'd9); tick();
    gamma(8'd5, 8'd9); tick();
    check("t2_rec", res_data_a, mk_rec(8'd4, 3'd1, 2'b10, 2'b00, 8'd1, 8'd3));
    pop_a();

    // T3: ch1 never converges, window runs to MAX_CYC
    start_a(8'd5);
    for (int c = 1; c <= 10; c++) begin
      gamma(8'd0, 8'd200);
      if (c == 9) begin tick(); check("t3_busy_c9", busy_a, 1); end
      else if (c < 10) tick();
    end
    tick();
    check("t3_busy_done", busy_a, 0);
    check("t3_rec", res_data_a, mk_rec(8'd5, 3'd0, 2'b00, 2'b10, 8'd10, 8'd1));
    pop_a();

    // T3b: no early stop, both converged by cycle 3, window still ends at cycle 10
    trans_id = 8'd6; trans_start_b = 1; tick(); trans_start_b = 0;
    for (int c = 1; c <= 10; c++) begin
      gamma((c >= 2) ? 8'd2 : 8'd9, (c >= 3) ? 8'd1 : 8'd9);
      if (c == 9) begin tick(); check("t3b_busy_c9", busy_b, 1); end
      else if (c < 10) tick();
    end
    tick();
    check("t3b_busy_done", busy_b, 0);
    check("t3b_valid", res_valid_b, 1);
    check("t3b_rec", res_data_b, mk_rec(8'd6, 3'd0, 2'b00, 2'b00, 8'd3, 8'd2));
    check("t3b_a_idle", res_valid_a, 0);

    // T4: trans_start while busy, with clr_flags in the same clk (set wins)
    start_a(8'd7);
    gamma(8'd9, 8'd9); tick();
    trans_id = 8'd8; trans_start_a = 1; clr_flags = 1; tick();
    trans_start_a = 0; clr_flags = 0;
    check("t4_coll_set", collision_a, 1);
    gamma(8'd0, 8'd0); tick();
    check("t4_rec", res_data_a, mk_rec(8'd7, 3'd0, 2'b00, 2'b00, 8'd2, 8'd2));
    pop_a();
    check("t4_one_rec", res_valid_a, 0);
    clr_flags = 1; tick(); clr_flags = 0;
    check("t4_coll_clr", collision_a, 0);

    // T5: nine records into a depth-8 FIFO with no consumer
    for (int i = 0; i < 9; i++) begin
      start_a(8'(10 + i));
      gamma(8'd0, 8'd0); tick();
      if (i == 7) check("t5_ovf_at8", overflow_a, 0);
    end
    check("t5_ovf", overflow_a, 1);
    check("t5_valid", res_valid_a, 1);
    for (int i = 0; i < 8; i++) begin
      check($sformatf("t5_rec%0d", i), res_data_a,
            mk_rec(8'(10 + i), 3'd0, 2'b00, 2'b00, 8'd1, 8'd1));
      pop_a();
    end
    check("t5_drained", res_valid_a, 0);

    // T5b: push into a full FIFO while popping is accepted
    clr_flags = 1; tick(); clr_flags = 0;
    check("t5b_ovf_clr", overflow_a, 0);
    for (int i = 0; i < 8; i++) begin
      start_a(8'(20 + i));
      gamma(8'd0, 8'd0); tick();
    end
    start_a(8'd28);
    gamma(8'd0, 8'd0);
    res_ready_a = 1; tick(); res_ready_a = 0;
    check("t5b_no_ovf", overflow_a, 0);
    for (int i = 0; i < 8; i++) begin
      check($sformatf("t5b_rec%0d", i), res_data_a,
            mk_rec(8'(21 + i), 3'd0, 2'b00, 2'b00, 8'd1, 8'd1));
      pop_a();
    end
    check("t5b_drained", res_valid_a, 0);

    // T6: reset at cycle 4 of a measurement, with one record already queued
    start_a(8'd29);
    gamma(8'd0, 8'd0); tick();
    start_a(8'd30);
    for (int c = 1; c <= 4; c++) begin
      gamma(8'd9, 8'd9);
      if (c < 4) tick();
    end
    rst = 1; #2;
    check("t6_busy", busy_a, 0);
    check("t6_valid", res_valid_a, 0);
    check("t6_data", res_data_a, 0);
    rst = 0; tick();
    start_a(8'd31);
    gamma(8'd9, 8'd0); tick();
    gamma(8'd0, 8'd9); tick();
    check("t6_valid_after", res_valid_a, 1);
    check("t6_rec", res_data_a, mk_rec(8'd31, 3'd1, 2'b10, 2'b00, 8'd1, 8'd2));
    pop_a();
    check("t6_drained", res_valid_a, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/conv_latency_monitor.md
Name: conv_latency_monitor

Overview:
- Hardware form of the A/B convergence-latency measurement used on the pst_2layer_cseq hierarchy experiments, generalised to N_CH channels.
- On each pattern transition it counts gamma cycles until each channel's prediction error falls within tolerance, or until a timeout.
- Each transition produces one result record that goes into a ready/valid result FIFO.
- Per-channel "faster than reference channel" flags and a fastest-channel index are computed in hardware, so long runs need no bench-side bookkeeping.

Parameters:
- N_CH, 2, number of monitored channels (DUT instances), 1..8
- ERR_W, 8, width of each channel error input
- CNT_W, 8, latency counter width
- TOL, 5, convergence threshold; a channel converges when err <= TOL
- MAX_CYC, 10, measurement window in gamma cycles, 1..2^CNT_W-1
- REF_CH, 0, baseline channel for the faster flags
- EARLY_STOP, 1, 1 = end the window as soon as all channels have converged; 0 = always run MAX_CYC cycles
- DEPTH, 8, result FIFO depth, power of 2

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- cycle_start  in  1  one-clk pulse at each gamma cycle boundary, from gamma_oscillator
- trans_start  in  1  one-clk pulse: the input pattern changed, begin a measurement
- trans_id  in  8  tag latched when trans_start is accepted
- err_in  in  N_CH*ERR_W  packed per-channel error; channel k occupies bits [k*ERR_W +: ERR_W]
- busy  out  1  a measurement is in progress
- res_valid  out  1  FIFO not empty
- res_ready  in  1  consumer pop
- res_data  out  REC_W  head record (format in Behaviour)
- overflow  out  1  sticky; a record was dropped because the FIFO was full
- collision  out  1  sticky; trans_start arrived while busy
- clr_flags  in  1  synchronous clear of overflow and collision

Behaviour:
- Reset (async, rst=1): state IDLE, busy=0, res_valid=0, res_data=0, overflow=0, collision=0, FIFO empty, all latency counters and masks cleared.
- State machine: IDLE -> MEASURE -> PUSH -> IDLE.
- IDLE:
  - trans_start=1 latches trans_id.
  - Clears cyc_cnt, per-channel lat, and conv_mask.
  - Goes to MEASURE; busy=1 from the next clock.
- MEASURE:
  - Channels are sampled only on clocks with cycle_start=1.
  - cyc_cnt increments first; the first sample after the start is cycle 1.
  - For each channel k with conv_mask[k]=0 and err_k <= TOL (unsigned): lat[k]=cyc_cnt, conv_mask[k]=1.
  - Go to PUSH when cyc_cnt reaches MAX_CYC, or when EARLY_STOP=1 and conv_mask is all ones.
  - A cycle_start that coincides with trans_start acceptance is not sampled.
- PUSH (exactly 1 clk):
  - Any channel with conv_mask[k]=0 gets lat[k]=MAX_CYC and timeout bit set.
  - Compute faster[k] = (lat[k] < lat[REF_CH]) and conv_mask[k]. faster[REF_CH] is always 0.
  - fastest = lowest index holding the minimum lat.
  - Write the record. If the FIFO is full and not popping this clk, drop the record and set overflow.
  - Then go to IDLE; busy=0.
- Record format, MSB to LSB: trans_id[7:0], fastest[2:0], faster[N_CH-1:0], timeout[N_CH-1:0], lat[N_CH-1]..lat[0] (CNT_W each). REC_W = 11 + 2*N_CH + N_CH*CNT_W.
- trans_start while busy (MEASURE or PUSH): ignored and sets collision. The current measurement continues unchanged.
- FIFO:
  - First-word fall-through; res_data is valid whenever res_valid=1.
  - A pop happens when res_valid and res_ready.
  - Push and pop on the same clk are both honoured, including when the FIFO is full.
  - Pop on empty is a no-op.
- clr_flags in the same clk as a new overflow or collision event: the set wins.
- Reset mid-measurement: everything returns to reset values, with no partial record.
- err_in is treated as quasi-static within a cycle. No synchroniser; same clock domain.

Decomposition:
- Package clm_pkg holds:
  - the state enum (IDLE, MEASURE, PUSH);
  - the REC_W function and record field offset functions;
  - the fastest-index width constant (3).
- One sub-module, clm_result_fifo: parametrised DEPTH x REC_W synchronous FWFT FIFO with count, full, and empty, using the same clk and rst.
- Min/argmin over channels is a combinational function in clm_pkg, not a separate module.

Test Plan:
- N_CH=2, MAX_CYC=10, EARLY_STOP=1. trans_start with id=3. Ch0 err drops to 4 at cycle 2, ch1 at cycle 5 -> record lat={5,2}, timeout=00, faster=00, fastest=0; busy deasserts 1 clk after cycle 5.
- Ch1 converges at cycle 1 and ch0 at cycle 3 -> faster=10, fastest=1. A value of err=5 exactly counts as converged; err=6 does not.
- Ch1 never below TOL -> after 10 cycle_starts the record has lat1=10, timeout=10; with EARLY_STOP=0 and both converged by cycle 3, the window still ends at cycle 10.
- trans_start pulsed while busy -> collision=1, only one record produced. clr_flags -> collision=0.
- DEPTH=8, res_ready=0, 9 transitions -> res_valid=1, 8 records in order of trans_id, overflow=1. A 9th push coinciding with a pop is accepted (no overflow).
- rst pulsed mid-MEASURE at cycle 4 -> busy=0, res_valid=0, no record. A following trans_start measures from cycle 1 afresh.
